regfile_wb_arbiter: RTL and testbench
=====================================

// Module: regfile_wb_arbiter
// PURPOSE
//  Shares the register file's single write port between two writeback sources:
//  S0 (ALU results) and S1 (load data). Each source has a small queue; one entry
//  per cycle is granted and drives rf_we/rf_wa/rf_wd. Also flags read addresses
//  that still have queued writes, so the decode stage can stall on them.
// PARAMETERS
//  DEPTH     2  entries per source queue (power of 2, >=2)
//  MAX_WAIT  3  max consecutive cycles a non-empty S0 may be denied before forced grant
// PORTS
//  clk       in   1   clock; all state updates on posedge
//  rst_n     in   1   asynchronous active-low reset
//  s0_valid  in   1   S0 (ALU) write request
//  s0_ready  out  1   S0 queue can accept
//  s0_addr   in   5   S0 destination register
//  s0_data   in   32  S0 write data
//  s1_valid  in   1   S1 (load) write request
//  s1_ready  out  1   S1 queue can accept
//  s1_addr   in   5   S1 destination register
//  s1_data   in   32  S1 write data
//  rf_we     out  1   register-file write enable
//  rf_wa     out  5   register-file write address
//  rf_wd     out  32  register-file write data
//  ra1, ra2  in   5   decode-stage read addresses to check
//  busy1     out  1   ra1 has a queued, uncommitted write
//  busy2     out  1   ra2 has a queued, uncommitted write
// BEHAVIOUR
//  Reset (rst_n low, async):
//   - Queues empty; wait counter = 0.
//   - rf_we = 0, busy1/busy2 = 0.
//   - s0_ready = s1_ready = 0 while rst_n is low.
//  Handshake:
//   - sN_ready = !fullN. Transfer at posedge when sN_valid && sN_ready.
//   - Payload must be held stable while valid && !ready.
//   - No pop-through: a full queue is not ready, even if it is popped that cycle.
//  x0 filtering: a request with addr==0 is accepted (transfer completes) but is
//   discarded. It is never queued, never raises busy, and never drives rf_we.
//  Grant, combinational from the queue heads:
//   - S1 has priority when both queues are non-empty.
//   - S0 wins if wait0 == MAX_WAIT.
//   - Exactly one head is popped per cycle when any queue is non-empty.
//   - rf_we = |nonempty; rf_wa/rf_wd = granted head. rf_wa/rf_wd = 0 when rf_we = 0.
//  Latency: accept at edge k -> earliest rf_we during cycle k+1 -> committed at edge k+1.
//  wait0:
//   - +1 per cycle when S0 is non-empty and not granted; saturates at MAX_WAIT.
//   - Cleared when S0 is granted or S0 is empty.
//  Ordering:
//   - FIFO order within a source.
//   - No cross-source ordering; WAW ordering between S0 and S1 is enforced by
//     the decoder using busy1/busy2.
//  busy:
//   - busyN = (raN != 0) && raN matches any valid entry in either queue.
//   - Covers the entry being popped this cycle: the write lands at the edge, and
//     the regfile read is valid the following cycle.
//   - Incoming (not yet queued) requests are not included.
//  Simultaneous events:
//   - Push and pop on the same queue in one cycle is legal; count unchanged.
//   - Both sources may push in the same cycle.
//  Reset mid-operation: queued writes are dropped; nothing reaches rf_we.
// STRUCTURE
//  Package rv_pkg:
//   - XLEN = 32, REG_AW = 5.
//   - typedef struct packed {logic [REG_AW-1:0] addr; logic [XLEN-1:0] data;} wb_req_t.
//  Sub-module wb_fifo:
//   - Synchronous FIFO of wb_req_t; async active-low reset.
//   - Exposes head, full, empty, plus per-entry valid/addr vectors for busy compare.
//   - Instantiated twice.
//  Top level: grant logic, wait0 counter, x0 filter, busy compare.
// TESTING
//  1. S0 push {addr 5, data 0xDEADBEEF} at edge k
//     -> rf_we=1, rf_wa=5, rf_wd=0xDEADBEEF in cycle k+1; busy1=1 for ra1=5 during cycle k+1 only.
//  2. S0 and S1 push in the same cycle ({3, 0x11}, {4, 0x22})
//     -> S1 write (4, 0x22) first, S0 write (3, 0x11) next cycle.
//  3. S1 streams every cycle while S0 holds one entry
//     -> S0 is granted no later than the 4th cycle after it becomes non-empty (MAX_WAIT=3).
//  4. S0 pushes 3 back-to-back with S1 saturating the port
//     -> s0_ready=0 after 2 accepts; the 3rd request is held and accepted after the S0 pop.
//  5. Push with addr=0, data=0xFFFFFFFF -> s0_ready=1, accepted; rf_we and busy never asserted.
//  6. Queue 2 entries, then pulse rst_n low mid-cycle
//     -> rf_we=0 immediately, queues empty, no write after release; ready=1 on the first edge after release.

Source files
------------

// File: rtl/rv_pkg.sv
// Shared register-file types for the writeback path.
package rv_pkg;

    localparam int unsigned XLEN   = 32;
    localparam int unsigned REG_AW = 5;

    typedef struct packed {
        logic [REG_AW-1:0] addr;
        logic [XLEN-1:0]   data;
    } wb_req_t;

endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// Writeback sources, register-file write port and hazard-check signals.
interface regfile_wb_arbiter_if;
    import rv_pkg::*;

    logic              s0_valid;
    logic              s0_ready;
    logic [REG_AW-1:0] s0_addr;
    logic [XLEN-1:0]   s0_data;
    logic              s1_valid;
    logic              s1_ready;
    logic [REG_AW-1:0] s1_addr;
    logic [XLEN-1:0]   s1_data;
    logic              rf_we;
    logic [REG_AW-1:0] rf_wa;
    logic [XLEN-1:0]   rf_wd;
    logic [REG_AW-1:0] ra1;
    logic [REG_AW-1:0] ra2;
    logic              busy1;
    logic              busy2;

    modport slave (
        input  s0_valid, s0_addr, s0_data,
        input  s1_valid, s1_addr, s1_data,
        input  ra1, ra2,
        output s0_ready, s1_ready,
        output rf_we, rf_wa, rf_wd,
        output busy1, busy2
    );

    modport master (
        output s0_valid, s0_addr, s0_data,
        output s1_valid, s1_addr, s1_data,
        output ra1, ra2,
        input  s0_ready, s1_ready,
        input  rf_we, rf_wa, rf_wd,
        input  busy1, busy2
    );

endinterface

// File: rtl/wb_fifo.sv
// Small writeback request FIFO; per-slot valid/addr are exported for hazard checks.
module wb_fifo
    import rv_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         push,
    input  logic                         pop,
    input  wb_req_t                      din,
    output wb_req_t                      head,
    output logic                         full,
    output logic                         empty,
    output logic [DEPTH-1:0]             entry_valid,
    output logic [DEPTH-1:0][REG_AW-1:0] entry_addr
);

    localparam int unsigned PW = (DEPTH < 2) ? 1 : $clog2(DEPTH);

    wb_req_t          mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [DEPTH-1:0] vld;

    // Push only when not full and pop only when not empty, so the two never hit the same slot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            vld    <= '0;
        end else begin
            if (push) begin
                wr_ptr      <= wr_ptr + PW'(1);
                vld[wr_ptr] <= 1'b1;
            end
            if (pop) begin
                rd_ptr      <= rd_ptr + PW'(1);
                vld[rd_ptr] <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= din;
        end
    end

    always_comb begin
        for (int unsigned i = 0; i < DEPTH; i++) begin
            entry_addr[i] = mem[i].addr;
        end
    end

    assign head        = mem[rd_ptr];
    assign full        = &vld;
    assign empty       = ~|vld;
    assign entry_valid = vld;

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Arbitrates the single register-file write port between ALU (S0) and load (S1) writebacks.
module regfile_wb_arbiter
    import rv_pkg::*;
#(
    parameter int unsigned DEPTH    = 2,
    parameter int unsigned MAX_WAIT = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    regfile_wb_arbiter_if.slave   bus
);

    localparam int unsigned WW = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);

    wb_req_t                      head0, head1;
    logic                         full0, full1, empty0, empty1;
    logic [DEPTH-1:0]             vld0, vld1;
    logic [DEPTH-1:0][REG_AW-1:0] addr0, addr1;
    logic                         push0, push1;
    logic                         ne0, ne1, force0, grant0, grant1;
    logic [WW-1:0]                wait0;
    logic                         ready0, ready1;
    logic                         busy1, busy2;

    // Writes to x0 complete the handshake but never enter a queue.
    assign ready0 = rst_n && !full0;
    assign ready1 = rst_n && !full1;
    assign push0  = bus.s0_valid && ready0 && (bus.s0_addr != '0);
    assign push1  = bus.s1_valid && ready1 && (bus.s1_addr != '0);

    wb_fifo #(.DEPTH(DEPTH)) u_fifo0 (
        .clk         (clk),
        .rst_n       (rst_n),
        .push        (push0),
        .pop         (grant0),
        .din         ('{addr: bus.s0_addr, data: bus.s0_data}),
        .head        (head0),
        .full        (full0),
        .empty       (empty0),
        .entry_valid (vld0),
        .entry_addr  (addr0)
    );

    wb_fifo #(.DEPTH(DEPTH)) u_fifo1 (
        .clk         (clk),
        .rst_n       (rst_n),
        .push        (push1),
        .pop         (grant1),
        .din         ('{addr: bus.s1_addr, data: bus.s1_data}),
        .head        (head1),
        .full        (full1),
        .empty       (empty1),
        .entry_valid (vld1),
        .entry_addr  (addr1)
    );

    assign ne0    = !empty0;
    assign ne1    = !empty1;
    assign force0 = ne0 && (wait0 == WW'(MAX_WAIT));
    assign grant1 = ne1 && !force0;
    assign grant0 = ne0 && !grant1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait0 <= '0;
        end else if (!ne0 || grant0) begin
            wait0 <= '0;
        end else if (wait0 != WW'(MAX_WAIT)) begin
            wait0 <= wait0 + WW'(1);
        end
    end

    // Entries being popped this cycle still count as busy: the regfile holds the value next cycle.
    always_comb begin
        busy1 = 1'b0;
        busy2 = 1'b0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if ((vld0[i] && addr0[i] == bus.ra1) || (vld1[i] && addr1[i] == bus.ra1)) busy1 = 1'b1;
            if ((vld0[i] && addr0[i] == bus.ra2) || (vld1[i] && addr1[i] == bus.ra2)) busy2 = 1'b1;
        end
        if (bus.ra1 == '0) busy1 = 1'b0;
        if (bus.ra2 == '0) busy2 = 1'b0;
    end

    always_comb begin
        bus.rf_we = ne0 || ne1;
        bus.rf_wa = '0;
        bus.rf_wd = '0;
        if (grant1) begin
            bus.rf_wa = head1.addr;
            bus.rf_wd = head1.data;
        end else if (grant0) begin
            bus.rf_wa = head0.addr;
            bus.rf_wd = head0.data;
        end
    end

    assign bus.s0_ready = ready0;
    assign bus.s1_ready = ready1;
    assign bus.busy1    = busy1;
    assign bus.busy2    = busy2;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed scenarios plus random traffic against a queue-based model of the writeback arbiter.
module tb_regfile_wb_arbiter;
    import rv_pkg::*;

    localparam int unsigned DEPTH    = 2;
    localparam int unsigned MAX_WAIT = 3;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    regfile_wb_arbiter_if bus ();

    regfile_wb_arbiter #(.DEPTH(DEPTH), .MAX_WAIT(MAX_WAIT)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    wb_req_t     q0[$];
    wb_req_t     q1[$];
    int unsigned w0   = 0;
    bit          acc0 = 1'b0;
    bit          acc1 = 1'b0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit queued(input logic [REG_AW-1:0] ra);
        if (ra == 0) return 1'b0;
        foreach (q0[i]) if (q0[i].addr == ra) return 1'b1;
        foreach (q1[i]) if (q1[i].addr == ra) return 1'b1;
        return 1'b0;
    endfunction

    // The load queue wins unless the ALU queue has already waited its limit.
    function automatic bit s1_turn();
        return (q1.size() != 0) && !((q0.size() != 0) && (w0 == MAX_WAIT));
    endfunction

    task automatic check_outputs();
        bit      we;
        wb_req_t w;
        we = (q0.size() + q1.size()) != 0;
        w  = '0;
        if (we) w = s1_turn() ? q1[0] : q0[0];
        check("s0_ready", 64'(bus.s0_ready), 64'(q0.size() < DEPTH));
        check("s1_ready", 64'(bus.s1_ready), 64'(q1.size() < DEPTH));
        check("rf_we",    64'(bus.rf_we),    64'(we));
        check("rf_wa",    64'(bus.rf_wa),    64'(w.addr));
        check("rf_wd",    64'(bus.rf_wd),    64'(w.data));
        check("busy1",    64'(bus.busy1),    64'(queued(bus.ra1)));
        check("busy2",    64'(bus.busy2),    64'(queued(bus.ra2)));
    endtask

    task automatic advance();
        bit      r0, r1, had0, took1;
        r0    = q0.size() < DEPTH;
        r1    = q1.size() < DEPTH;
        had0  = q0.size() != 0;
        took1 = s1_turn();
        if (took1) void'(q1.pop_front());
        else if (had0) void'(q0.pop_front());
        if (had0 && took1) w0 = (w0 < MAX_WAIT) ? w0 + 1 : MAX_WAIT;
        else w0 = 0;
        acc0 = bus.s0_valid && r0;
        acc1 = bus.s1_valid && r1;
        if (acc0 && bus.s0_addr != 0) q0.push_back('{addr: bus.s0_addr, data: bus.s0_data});
        if (acc1 && bus.s1_addr != 0) q1.push_back('{addr: bus.s1_addr, data: bus.s1_data});
    endtask

    task automatic step();
        @(negedge clk);
        check_outputs();
        advance();
        @(posedge clk);
        #1;
    endtask

    task automatic drive0(input bit v, input logic [REG_AW-1:0] a, input logic [XLEN-1:0] d);
        bus.s0_valid = v;
        bus.s0_addr  = a;
        bus.s0_data  = d;
    endtask

    task automatic drive1(input bit v, input logic [REG_AW-1:0] a, input logic [XLEN-1:0] d);
        bus.s1_valid = v;
        bus.s1_addr  = a;
        bus.s1_data  = d;
    endtask

    // Payload may only change once the previous offer has been taken.
    task automatic stream1();
        if (!bus.s1_valid || acc1) drive1(1'b1, 5'($urandom_range(8, 15)), $urandom);
    endtask

    task automatic model_reset();
        q0.delete();
        q1.delete();
        w0   = 0;
        acc0 = 1'b0;
        acc1 = 1'b0;
    endtask

    initial begin
        int unsigned sent;
        int unsigned p0, p1;
        drive0(1'b0, '0, '0);
        drive1(1'b0, '0, '0);
        bus.ra1 = '0;
        bus.ra2 = '0;

        #12;
        check("rst s0_ready", 64'(bus.s0_ready), 64'd0);
        check("rst s1_ready", 64'(bus.s1_ready), 64'd0);
        check("rst rf_we",    64'(bus.rf_we),    64'd0);
        check("rst busy1",    64'(bus.busy1),    64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Single ALU write: visible on the port one cycle after acceptance.
        drive0(1'b1, 5'd5, 32'hDEADBEEF);
        bus.ra1 = 5'd5;
        step();
        drive0(1'b0, '0, '0);
        step();
        step();

        // Simultaneous pushes: load result first.
        drive0(1'b1, 5'd3, 32'h11);
        drive1(1'b1, 5'd4, 32'h22);
        bus.ra1 = 5'd3;
        bus.ra2 = 5'd4;
        step();
        drive0(1'b0, '0, '0);
        drive1(1'b0, '0, '0);
        repeat (3) step();

        // Load stream starves a single ALU entry until the wait limit forces it through.
        drive0(1'b1, 5'd7, 32'hA0A0A0A0);
        drive1(1'b1, 5'd9, 32'h900D);
        bus.ra1 = 5'd7;
        step();
        drive0(1'b0, '0, '0);
        repeat (8) begin
            stream1();
            step();
        end
        drive1(1'b0, '0, '0);
        repeat (4) step();

        // Three ALU writes against a saturated port: third offer stalls until a pop.
        sent = 0;
        repeat (14) begin
            if (!bus.s0_valid || acc0) begin
                if (sent < 3) begin
                    drive0(1'b1, 5'(20 + sent), 32'hC0DE0000 + sent);
                    sent++;
                end else begin
                    drive0(1'b0, '0, '0);
                end
            end
            stream1();
            bus.ra1 = 5'd22;
            step();
        end
        drive0(1'b0, '0, '0);
        drive1(1'b0, '0, '0);
        repeat (5) step();

        // x0 writes are consumed silently.
        drive0(1'b1, 5'd0, 32'hFFFFFFFF);
        bus.ra1 = 5'd0;
        bus.ra2 = 5'd0;
        step();
        drive0(1'b0, '0, '0);
        repeat (2) step();

        // Reset in the middle of a cycle drops queued writes immediately.
        drive0(1'b1, 5'd12, 32'h1234);
        drive1(1'b1, 5'd13, 32'h5678);
        bus.ra1 = 5'd12;
        bus.ra2 = 5'd13;
        step();
        drive0(1'b0, '0, '0);
        drive1(1'b0, '0, '0);
        @(negedge clk);
        check_outputs();
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check("midrst rf_we",    64'(bus.rf_we),    64'd0);
        check("midrst s0_ready", 64'(bus.s0_ready), 64'd0);
        check("midrst s1_ready", 64'(bus.s1_ready), 64'd0);
        check("midrst busy1",    64'(bus.busy1),    64'd0);
        check("midrst busy2",    64'(bus.busy2),    64'd0);
        @(posedge clk);
        #1;
        check("inrst rf_we", 64'(bus.rf_we), 64'd0);
        @(negedge clk);
        #2;
        rst_n = 1'b1;
        #1;
        check_outputs();
        @(posedge clk);
        #1;
        repeat (3) step();

        // Random traffic with varying load on each source.
        for (int unsigned i = 0; i < 3000; i++) begin
            if (i % 500 == 0) begin
                p0 = $urandom_range(20, 95);
                p1 = $urandom_range(20, 95);
            end
            if (!bus.s0_valid || acc0)
                drive0($urandom_range(99) < p0, 5'($urandom_range(0, 7)), $urandom);
            if (!bus.s1_valid || acc1)
                drive1($urandom_range(99) < p1, 5'($urandom_range(0, 7)), $urandom);
            bus.ra1 = 5'($urandom_range(0, 7));
            bus.ra2 = 5'($urandom_range(0, 7));
            step();
        end
        drive0(1'b0, '0, '0);
        drive1(1'b0, '0, '0);
        repeat (4) step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
